// File: rtl/bitmap_blit.sv
// bitmap_blit: draws a ROM bitmap as a grid of solid colour cells through a VGA pixel write port.
// Ports: fastclock/resetn (sync, active-low); start, origin_x/origin_y, fg_colour/bg_colour (frame request, latched in IDLE);
//        row_addr -> ROM, row_data <- ROM (one-cycle latency, column c at bit COLS-1-c);
//        x, y, colour, plot (pixel writes); busy, done (frame status).
// Option: define BLIT_SKIP_BG_EN to skip drawing cells whose bit is clear.
module bitmap_blit #(
  parameter int COLS = 16,
  parameter int ROWS = 16,
  parameter int CELL_W = 8,
  parameter int CELL_H = 8,
  parameter int X_STEP = 10,
  parameter int Y_STEP = 7,
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1,
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1
) (
  input  logic            fastclock,
  input  logic            resetn,
  input  logic            start,
  input  logic [7:0]      origin_x,
  input  logic [6:0]      origin_y,
  input  logic [2:0]      fg_colour,
  input  logic [2:0]      bg_colour,
  output logic [RW-1:0]   row_addr,
  input  logic [COLS-1:0] row_data,
  output logic [7:0]      x,
  output logic [6:0]      y,
  output logic [2:0]      colour,
  output logic            plot,
  output logic            busy,
  output logic            done
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, CELL, DRAW, DONE} state_t;
  state_t state, state_nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [3:0] px, py;
  logic [7:0] ox;
  logic [6:0] oy;
  logic [2:0] fg, bg, colour_r;
  logic [COLS-1:0] row_reg;
  logic cur_bit, skip, last_px, last_col, last_row, adv;
  assign cur_bit = row_reg[CW'(COLS-1) - col];
  assign last_px = px == 4'(CELL_W-1) && py == 4'(CELL_H-1);
  assign last_col = col == CW'(COLS-1);
  assign last_row = row == RW'(ROWS-1);
`ifdef BLIT_SKIP_BG_EN
  assign skip = !cur_bit;
`else
  assign skip = 1'b0;
`endif
  // coordinates wrap naturally by truncating to the port widths
  assign x = 8'(32'(ox) + 32'(col) * 32'(X_STEP) + 32'(px));
  assign y = 7'(32'(oy) + 32'(row) * 32'(Y_STEP) + 32'(py));
  always_ff @(posedge fastclock)
    state <= !resetn ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    adv = 1'b0;
    plot = state == DRAW;
    busy = state != IDLE;
    done = state == DONE;
    row_addr = row;
    colour = colour_r;
    case (state)
      IDLE:    state_nxt = start ? FETCH : IDLE;
      FETCH:   state_nxt = WAIT;
      WAIT:    state_nxt = CELL;
      CELL:    begin adv = skip; state_nxt = DRAW; end
      DRAW:    adv = last_px;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // end of a cell: next column, next row, or finish
    if (adv) state_nxt = !last_col ? CELL : !last_row ? FETCH : DONE;
  end
  always_ff @(posedge fastclock) begin
    if (!resetn) begin
      row <= '0;
      col <= '0;
      px <= '0;
      py <= '0;
      ox <= '0;
      oy <= '0;
      fg <= '0;
      bg <= '0;
      colour_r <= '0;
      row_reg <= '0;
    end else begin
      if (state == IDLE && start) begin
        ox <= origin_x;
        oy <= origin_y;
        fg <= fg_colour;
        bg <= bg_colour;
        row <= '0;
        col <= '0;
      end
      if (state == WAIT) begin
        row_reg <= row_data;
        col <= '0;
      end
      if (state == CELL) begin
        colour_r <= cur_bit ? fg : bg;
        px <= '0;
        py <= '0;
      end
      if (state == DRAW) begin
        px <= px == 4'(CELL_W-1) ? '0 : px + 1'b1;
        py <= px == 4'(CELL_W-1) ? py + 1'b1 : py;
      end
      if (adv) begin
        col <= last_col ? '0 : col + 1'b1;
        row <= last_col && !last_row ? row + 1'b1 : row;
      end
    end
  end
endmodule

// File: tb/tb_bitmap_blit.sv
// tb_bitmap_blit: scoreboard bench for bitmap_blit, one small-parameter instance and one default instance.
module tb_bitmap_blit;
  logic fastclock = 0, resetn = 0;
  always #5 fastclock = ~fastclock;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge fastclock) cyc <= cyc + 1;

`ifdef BLIT_SKIP_BG_EN
  localparam int LEN_A = 9, LEN_B = 2337, LAST_IDX = 1984;
`else
  localparam int LEN_A = 13, LEN_B = 16673, LAST_IDX = 16320;
`endif

  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
  pix_t qa[$], qb[$];
  pix_t ea, eb, last_pix;

  logic start_a = 0;
  logic [7:0] ox_a = 0;
  logic [6:0] oy_a = 0;
  logic [2:0] fg_a = 0, bg_a = 0;
  logic [0:0] ra_a;
  logic [1:0] rd_a = 0;
  logic [7:0] x_a;
  logic [6:0] y_a;
  logic [2:0] c_a;
  logic plot_a, busy_a, done_a;

  logic start_b = 0;
  logic [7:0] ox_b = 0;
  logic [6:0] oy_b = 0;
  logic [2:0] fg_b = 0, bg_b = 0;
  logic [3:0] ra_b;
  logic [15:0] rd_b = 0;
  logic [15:0] rom_b [16];
  logic [7:0] x_b;
  logic [6:0] y_b;
  logic [2:0] c_b;
  logic plot_b, busy_b, done_b;

  always @(posedge fastclock) rd_a <= 2'b10;
  always @(posedge fastclock) rd_b <= rom_b[ra_b];

  bitmap_blit #(.COLS(2), .ROWS(1), .CELL_W(2), .CELL_H(2), .X_STEP(3), .Y_STEP(3)) dut_a (
    .fastclock(fastclock), .resetn(resetn), .start(start_a), .origin_x(ox_a), .origin_y(oy_a),
    .fg_colour(fg_a), .bg_colour(bg_a), .row_addr(ra_a), .row_data(rd_a), .x(x_a), .y(y_a),
    .colour(c_a), .plot(plot_a), .busy(busy_a), .done(done_a));

  bitmap_blit dut_b (
    .fastclock(fastclock), .resetn(resetn), .start(start_b), .origin_x(ox_b), .origin_y(oy_b),
    .fg_colour(fg_b), .bg_colour(bg_b), .row_addr(ra_b), .row_data(rd_b), .x(x_b), .y(y_b),
    .colour(c_b), .plot(plot_b), .busy(busy_b), .done(done_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge fastclock);
    #1;
  endtask

  function automatic pix_t mk(input int xx, input int yy, input logic [2:0] cc);
    return {8'(xx), 7'(yy), cc};
  endfunction

  // instance A frame: cell 0 (bit set) at x0, cell 1 (bit clear) at x0+3
  task automatic push_a(input int x0, input int y0, input logic [2:0] f, input logic [2:0] b);
    qa.push_back(mk(x0, y0, f));
    qa.push_back(mk(x0 + 1, y0, f));
    qa.push_back(mk(x0, y0 + 1, f));
    qa.push_back(mk(x0 + 1, y0 + 1, f));
`ifndef BLIT_SKIP_BG_EN
    qa.push_back(mk(x0 + 3, y0, b));
    qa.push_back(mk(x0 + 4, y0, b));
    qa.push_back(mk(x0 + 3, y0 + 1, b));
    qa.push_back(mk(x0 + 4, y0 + 1, b));
`endif
  endtask

  task automatic gen_b(input int ox, input int oy, input logic [2:0] f, input logic [2:0] b);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        logic bitv;
        bitv = rom_b[r][15 - c];
`ifdef BLIT_SKIP_BG_EN
        if (!bitv) continue;
`endif
        for (int py = 0; py < 8; py++)
          for (int px = 0; px < 8; px++)
            qb.push_back(mk(ox + c * 10 + px, oy + r * 7 + py, bitv ? f : b));
      end
  endtask

  int dcnt_a = 0, dcnt_b = 0, fetch_a = 0, fetch_b = 0, len_a = 0, len_b = 0, nplot_b = 0;
  logic busy_pa = 0, busy_pb = 0;
  int seen[$];
  int wx[64], wy[64];

  always @(negedge fastclock) begin
    if (busy_a && !busy_pa) fetch_a = cyc;
    if (done_a) begin dcnt_a++; len_a = cyc - fetch_a + 1; end
    busy_pa = busy_a;
    if (plot_a) begin
      if (qa.size() == 0) chk("a_extra_plot", 1, 0);
      else begin ea = qa.pop_front(); chk("a_pixel", {x_a, y_a, c_a}, ea); end
    end
  end

  always @(negedge fastclock) begin
    if (busy_b && !busy_pb) begin
      fetch_b = cyc;
      nplot_b = 0;
      seen.delete();
      seen.push_back(int'(ra_b));
    end else if (busy_b && seen.size() > 0 && int'(ra_b) != seen[$]) seen.push_back(int'(ra_b));
    if (done_b) begin dcnt_b++; len_b = cyc - fetch_b + 1; end
    busy_pb = busy_b;
    if (plot_b) begin
      if (nplot_b < 64) begin wx[nplot_b] = int'(x_b); wy[nplot_b] = int'(y_b); end
      if (nplot_b == LAST_IDX) last_pix = {x_b, y_b, c_b};
      nplot_b++;
      if (qb.size() == 0) chk("b_extra_plot", 1, 0);
      else begin eb = qb.pop_front(); chk("b_pixel", {x_b, y_b, c_b}, eb); end
    end
  end

  task automatic wait_done(input bit b, input int n, input int lim);
    int d0, i;
    d0 = b ? dcnt_b : dcnt_a;
    i = 0;
    while ((b ? dcnt_b : dcnt_a) - d0 < n && i < lim) begin tick(1); i++; end
    if ((b ? dcnt_b : dcnt_a) - d0 < n) chk(b ? "b_done_timeout" : "a_done_timeout", 0, 1);
  endtask

  initial begin
    int d0, i, ok;
    int hx[8] = '{250, 251, 252, 253, 254, 255, 0, 1};
    int hy[8] = '{125, 126, 127, 0, 1, 2, 3, 4};
    for (int r = 0; r < 16; r++) rom_b[r] = 16'h8001;
    tick(3);
    chk("rst_a_outputs", {plot_a, busy_a, done_a, x_a, y_a, c_a, ra_a}, 0);
    chk("rst_b_plot_busy_done", {plot_b, busy_b, done_b}, 0);
    chk("rst_b_xy", {x_b, y_b}, 0);
    chk("rst_b_colour_row", {c_b, ra_b}, 0);
    resetn = 1;
    tick(2);

    ox_a = 10; oy_a = 20; fg_a = 3'b110; bg_a = 3'b001;
    push_a(10, 20, 3'b110, 3'b001);
    start_a = 1;
    tick(1);
    start_a = 0;
    wait_done(0, 1, 100);
    chk("a_frame_len", len_a, LEN_A);
    tick(2);
    chk("a_queue_empty1", qa.size(), 0);

    push_a(10, 20, 3'b110, 3'b001);
    d0 = dcnt_a;
    start_a = 1;
    tick(1);
    start_a = 0;
    tick(3);
    ox_a = 99; oy_a = 5; fg_a = 3'b000; bg_a = 3'b111;
    start_a = 1;
    tick(2);
    start_a = 0;
    wait_done(0, 1, 100);
    chk("a_len_midframe_changes", len_a, LEN_A);
    tick(20);
    chk("a_no_restart_done", dcnt_a - d0, 1);
    chk("a_no_restart_busy", busy_a, 0);
    chk("a_queue_empty2", qa.size(), 0);

    ox_a = 0; oy_a = 0; fg_a = 3'b111; bg_a = 3'b010;
    push_a(0, 0, 3'b111, 3'b010);
    push_a(0, 0, 3'b111, 3'b010);
    d0 = dcnt_a;
    start_a = 1;
    wait_done(0, 2, 100);
    start_a = 0;
    tick(20);
    chk("a_held_start_frames", dcnt_a - d0, 2);
    chk("a_held_start_len", len_a, LEN_A);
    chk("a_queue_empty3", qa.size(), 0);

    ox_b = 0; oy_b = 0; fg_b = 3'b101; bg_b = 3'b010;
    gen_b(0, 0, 3'b101, 3'b010);
    start_b = 1;
    tick(1);
    start_b = 0;
    wait_done(1, 1, 20000);
    chk("b_frame_len", len_b, LEN_B);
    ok = seen.size() == 16;
    for (int k = 0; k < 16 && ok; k++) if (seen[k] != k) ok = 0;
    chk("b_row_addr_seq", ok, 1);
    chk("b_last_cell_first_pix", last_pix, {8'd150, 7'd105, 3'b101});
    tick(2);
    chk("b_queue_empty1", qb.size(), 0);

    for (int r = 0; r < 16; r++) rom_b[r] = 16'hA5C3;
    ox_b = 7; oy_b = 3; fg_b = 3'b011; bg_b = 3'b100;
    gen_b(7, 3, 3'b011, 3'b100);
    start_b = 1;
    tick(1);
    start_b = 0;
    i = 0;
    while (!(plot_b && ra_b == 4'd3) && i < 20000) begin tick(1); i++; end
    chk("b_reach_row3_draw", plot_b && ra_b == 4'd3, 1);
    d0 = dcnt_b;
    resetn = 0;
    tick(1);
    qb.delete();
    chk("b_abort_plot", plot_b, 0);
    chk("b_abort_busy", busy_b, 0);
    resetn = 1;
    tick(5);
    chk("b_abort_no_done", dcnt_b - d0, 0);

    for (int r = 0; r < 16; r++) rom_b[r] = 16'h0000;
    rom_b[0] = 16'h8000;
    ox_b = 250; oy_b = 125; fg_b = 3'b100; bg_b = 3'b011;
    gen_b(250, 125, 3'b100, 3'b011);
    start_b = 1;
    tick(1);
    start_b = 0;
    wait_done(1, 1, 20000);
    chk("b_fresh_first_row", seen.size() > 0 ? seen[0] : -1, 0);
    for (int k = 0; k < 8; k++) chk("b_wrap_x", wx[k], hx[k]);
    for (int k = 0; k < 8; k++) chk("b_wrap_y", wy[k * 8], hy[k]);
    tick(2);
    chk("b_queue_empty2", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
